// File: rtl/sw_pkg.sv
// Shared types for the switch input stage: FIFO entry, channel/arbiter states,
// and pointer-width helper.
package sw_pkg;

  localparam int unsigned SW_DATA_W = 8;

  typedef struct packed {
    logic                 last;
    logic [SW_DATA_W-1:0] data;
  } fifo_entry_t;

  typedef enum logic {
    CH_ACCEPT,
    CH_DROP
  } ch_state_e;

  typedef enum logic {
    ARB_IDLE,
    ARB_XFER
  } arb_state_e;

  // One extra bit so full and empty are distinguishable with wrapping pointers.
  function automatic int unsigned ptr_w(input int unsigned depth);
    return 32'($clog2(depth)) + 32'd1;
  endfunction

endpackage

// File: rtl/sw_ch_fifo.sv
// One input channel: hold register, packet FIFO with commit/rewind, busy and
// drop flags. Only committed (complete) packets are visible to the reader.
module sw_ch_fifo
  import sw_pkg::*;
#(
  parameter int unsigned DATA_W     = SW_DATA_W,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned BUSY_THR   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] data_i,
  input  logic              en_i,
  input  logic              rd_en_i,
  output logic              avail_c_o,
  output fifo_entry_t       head_c_o,
  output logic              busy_o,
  output logic              drop_o
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned PW = ptr_w(FIFO_DEPTH);

  fifo_entry_t mem [FIFO_DEPTH];

  ch_state_e             state_q, state_d;
  logic [SW_DATA_W-1:0]  hold_q, hold_d;
  logic                  hold_valid_q, hold_valid_d;
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         commit_ptr_q, commit_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic                  busy_q, busy_d;
  logic                  drop_q, drop_d;
  logic                  we_c;
  fifo_entry_t           wentry_c;
  logic [PW-1:0]         used_c;
  logic                  full_c;

  assign avail_c_o = (commit_ptr_q != rd_ptr_q);
  // Head follows the post-read pointer so the arbiter can prefetch the next byte.
  assign head_c_o  = mem[rd_ptr_d[AW-1:0]];
  assign busy_o    = busy_q;
  assign drop_o    = drop_q;

  // Full check uses registered pointers: a same-edge read frees space only next edge.
  assign used_c = wr_ptr_q - rd_ptr_q;
  assign full_c = (used_c == PW'(FIFO_DEPTH));

  always_comb begin
    state_d      = state_q;
    hold_d       = hold_q;
    hold_valid_d = hold_valid_q;
    wr_ptr_d     = wr_ptr_q;
    commit_ptr_d = commit_ptr_q;
    rd_ptr_d     = rd_ptr_q + PW'(rd_en_i && avail_c_o);
    drop_d       = 1'b0;
    we_c         = 1'b0;
    wentry_c     = '0;

    case (state_q)
      CH_ACCEPT: begin
        if (en_i || hold_valid_q) begin
          if (hold_valid_q && full_c) begin
            wr_ptr_d     = commit_ptr_q;
            hold_valid_d = 1'b0;
            drop_d       = 1'b1;
            state_d      = CH_DROP;
          end else begin
            if (hold_valid_q) begin
              we_c          = 1'b1;
              wentry_c.last = ~en_i;
              wentry_c.data = hold_q;
              wr_ptr_d      = wr_ptr_q + PW'(1);
            end
            if (en_i) begin
              hold_d       = SW_DATA_W'(data_i);
              hold_valid_d = 1'b1;
            end else begin
              hold_valid_d = 1'b0;
              commit_ptr_d = wr_ptr_q + PW'(1);
            end
          end
        end
      end
      CH_DROP: begin
        if (!en_i) state_d = CH_ACCEPT;
      end
      default: state_d = CH_ACCEPT;
    endcase

    busy_d = (PW'(FIFO_DEPTH) - (wr_ptr_d - rd_ptr_d)) < PW'(BUSY_THR);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= CH_ACCEPT;
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
      wr_ptr_q     <= '0;
      commit_ptr_q <= '0;
      rd_ptr_q     <= '0;
      busy_q       <= 1'b0;
      drop_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      hold_q       <= hold_d;
      hold_valid_q <= hold_valid_d;
      wr_ptr_q     <= wr_ptr_d;
      commit_ptr_q <= commit_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      busy_q       <= busy_d;
      drop_q       <= drop_d;
    end
  end

  // Storage array carries no reset; pointers alone define its contents.
  always_ff @(posedge clk) begin
    if (we_c) mem[wr_ptr_q[AW-1:0]] <= wentry_c;
  end

endmodule

// File: rtl/sw_input_stage.sv
// Multi-channel switch input stage: per-channel packet FIFOs feeding a
// round-robin arbiter onto a single valid/ready byte stream.
module sw_input_stage
  import sw_pkg::*;
#(
  parameter int unsigned NUM_CH     = 4,
  parameter int unsigned DATA_W     = SW_DATA_W,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned BUSY_THR   = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_CH*DATA_W-1:0]   data_in,
  input  logic [NUM_CH-1:0]          sw_enable_in,
  output logic [NUM_CH-1:0]          busy_out,
  output logic [NUM_CH-1:0]          drop_out,
  output logic [DATA_W-1:0]          out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       out_sop,
  output logic                       out_eop,
  output logic [$clog2(NUM_CH)-1:0]  out_ch
);

  localparam int unsigned CH_W = $clog2(NUM_CH);

  logic [NUM_CH-1:0] avail_c;
  logic [NUM_CH-1:0] rd_en_c;
  fifo_entry_t       head_c [NUM_CH];

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    sw_ch_fifo #(
      .DATA_W     (DATA_W),
      .FIFO_DEPTH (FIFO_DEPTH),
      .BUSY_THR   (BUSY_THR)
    ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .data_i    (data_in[g*DATA_W +: DATA_W]),
      .en_i      (sw_enable_in[g]),
      .rd_en_i   (rd_en_c[g]),
      .avail_c_o (avail_c[g]),
      .head_c_o  (head_c[g]),
      .busy_o    (busy_out[g]),
      .drop_o    (drop_out[g])
    );
  end

  arb_state_e           arb_q, arb_d;
  logic [CH_W-1:0]      last_grant_q, last_grant_d;
  logic [CH_W-1:0]      ch_q, ch_d;
  logic [SW_DATA_W-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 sop_q, sop_d;
  logic                 eop_q, eop_d;

  logic                 grant_found_c;
  logic [CH_W-1:0]      grant_c;
  logic [CH_W-1:0]      cand_c;
  logic [CH_W-1:0]      sel_c;
  fifo_entry_t          head_sel_c;

  // Round-robin search starting just after the last served channel.
  always_comb begin
    grant_found_c = 1'b0;
    grant_c       = '0;
    cand_c        = '0;
    for (int unsigned i = 1; i <= NUM_CH; i++) begin
      cand_c = CH_W'((32'(last_grant_q) + i) % NUM_CH);
      if (!grant_found_c && avail_c[cand_c]) begin
        grant_found_c = 1'b1;
        grant_c       = cand_c;
      end
    end
  end

  assign sel_c      = (arb_q == ARB_IDLE) ? grant_c : ch_q;
  assign head_sel_c = head_c[sel_c];

  always_comb begin
    rd_en_c = '0;
    if (arb_q == ARB_XFER && valid_q && out_ready) rd_en_c[ch_q] = 1'b1;
  end

  always_comb begin
    arb_d        = arb_q;
    last_grant_d = last_grant_q;
    ch_d         = ch_q;
    data_d       = data_q;
    valid_d      = valid_q;
    sop_d        = sop_q;
    eop_d        = eop_q;
    case (arb_q)
      ARB_IDLE: begin
        if (grant_found_c) begin
          arb_d   = ARB_XFER;
          ch_d    = grant_c;
          valid_d = 1'b1;
          sop_d   = 1'b1;
          data_d  = head_sel_c.data;
          eop_d   = head_sel_c.last;
        end
      end
      ARB_XFER: begin
        if (out_ready) begin
          if (eop_q) begin
            arb_d        = ARB_IDLE;
            last_grant_d = ch_q;
            valid_d      = 1'b0;
            sop_d        = 1'b0;
            eop_d        = 1'b0;
          end else begin
            sop_d  = 1'b0;
            data_d = head_sel_c.data;
            eop_d  = head_sel_c.last;
          end
        end
      end
      default: arb_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      arb_q        <= ARB_IDLE;
      last_grant_q <= CH_W'(NUM_CH - 1);
      ch_q         <= '0;
      data_q       <= '0;
      valid_q      <= 1'b0;
      sop_q        <= 1'b0;
      eop_q        <= 1'b0;
    end else begin
      arb_q        <= arb_d;
      last_grant_q <= last_grant_d;
      ch_q         <= ch_d;
      data_q       <= data_d;
      valid_q      <= valid_d;
      sop_q        <= sop_d;
      eop_q        <= eop_d;
    end
  end

  assign out_data  = DATA_W'(data_q);
  assign out_valid = valid_q;
  assign out_sop   = sop_q;
  assign out_eop   = eop_q;
  assign out_ch    = ch_q;

endmodule

// File: doc/sw_input_stage.md
Name: sw_input_stage

Overview:
- Parametrised multi-channel switch input stage with NUM_CH serial byte inputs.
- Each channel frames packets with its own enable: bytes are accepted while enable is high, and the falling edge ends the packet.
- Each channel buffers packets in a private FIFO and commits only complete packets; a packet that overflows is dropped whole.
- A round-robin arbiter forwards committed packets, one at a time, onto a single valid/ready stream into the switch core.

Parameters:
- NUM_CH, 4, number of input channels (≥2).
- DATA_W, 8, byte width.
- FIFO_DEPTH, 16, entries per channel FIFO (power of two, ≥4).
- BUSY_THR, 4, busy_out asserts when free entries < BUSY_THR.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- data_in  in  NUM_CH×DATA_W  per-channel serial byte.
- sw_enable_in  in  NUM_CH  per-channel packet enable.
- busy_out  out  NUM_CH  per-channel FIFO nearly full (level).
- drop_out  out  NUM_CH  one-cycle pulse: packet dropped.
- out_data  out  DATA_W  forwarded byte.
- out_valid  out  1  out_data valid.
- out_ready  in  1  sink accepts byte.
- out_sop  out  1  first byte of packet.
- out_eop  out  1  last byte of packet.
- out_ch  out  $clog2(NUM_CH)  source channel of current packet.

Behaviour:
- Reset: one clock, clk; reset is asynchronous and active-low on rst_n.
  - rst_n low clears all pointers, hold registers, state and last-grant. Last-grant resets to NUM_CH-1.
  - Outputs during reset: out_valid, out_sop, out_eop and drop_out are 0; out_data and out_ch are 0; busy_out is 0.
  - Reset mid-packet discards all buffered and partial data. There is no output after release until new packets commit.
- Per-channel write side:
  - Pointers: wr_ptr, commit_ptr and rd_ptr, each $clog2(FIFO_DEPTH)+1 bits and wrapping naturally.
  - Entry format: {last, data}.
  - Hold register: one byte, plus hold_valid.
- Per-channel states:
  - ACCEPT, en=1: if hold_valid, write hold with last=0; then load data_in into hold and set hold_valid.
  - ACCEPT, en=0 with hold_valid: write hold with last=1, clear hold_valid, and set commit_ptr to the post-write wr_ptr in the same edge.
  - ACCEPT, en=0 without hold_valid: idle.
  - Single-byte packet (en high for one cycle): committed with last=1 on the next edge.
  - Full FIFO (wr_ptr−rd_ptr == FIFO_DEPTH) at any write attempt: no write, wr_ptr rewinds to commit_ptr, hold_valid clears, drop_out pulses one cycle, state goes to DROP.
  - DROP: ignore data_in; return to ACCEPT on the first edge sampling en=0.
  - Consequence: packets longer than FIFO_DEPTH are always dropped. Earlier committed packets are unaffected.
  - busy_out = (FIFO_DEPTH − (wr_ptr−rd_ptr)) < BUSY_THR, registered.
  - A read in the same edge as a write frees space before the full check of the next edge, never the same edge.
- Arbiter (states IDLE, XFER):
  - IDLE: a channel is eligible when commit_ptr != rd_ptr.
  - IDLE: grant the first eligible channel after last-grant in ascending wrap order, latch out_ch, go to XFER.
  - XFER: out_valid=1, out_data/out_eop from FIFO[rd_ptr] of the granted channel. out_sop=1 on the first byte of the packet.
  - On out_valid&&out_ready: rd_ptr++.
  - If that byte is last: update last-grant, return to IDLE.
  - Exactly one IDLE cycle between packets.
  - out_ready low: all outputs hold stable.
  - Reads never pass commit_ptr; uncommitted bytes are invisible.
- Latency: let edge E be the first edge sampling en=0 after a packet; commit occurs at E. Grant occurs at E+1, out_valid is high after E+1, and first-byte transfer happens at E+2 at the earliest.
- Simultaneous events: a commit and a read on the same channel in one edge are both honoured. A drop while the arbiter reads an older packet of that channel does not disturb the read.

Decomposition:
- Package sw_pkg: the FIFO entry struct {last, data} and the channel-state enum (ACCEPT, DROP).
- Package sw_pkg: the arbiter state enum (IDLE, XFER) and a clog2-based width localparam helper.
- Sub-module sw_ch_fifo: one channel's hold register, FIFO, commit/rewind logic, busy and drop outputs. It is instantiated NUM_CH times in a generate loop.
- Top level: arbiter and output mux.

Test Plan:
- Single packet:
  - Stimulus: ch0 sends 0xA1,0xA2,0xA3 (en high for 3 cycles), out_ready=1.
  - Response: out bytes A1(sop),A2,A3(eop), out_ch=0; first transfer at E+2; drop_out stays 0.
- Single-byte packet:
  - Stimulus: ch1 en high for 1 cycle with 0x5C.
  - Response: one transfer 0x5C with sop=eop=1, out_ch=1.
- Round robin:
  - Stimulus: after reset, ch2 and ch0 both commit 2-byte packets in the same cycle.
  - Response: ch0 packet first, then ch2. A following ch0 packet, with ch2 also pending, is served after ch2.
- Overflow:
  - Stimulus: FIFO_DEPTH=16, out_ready=0; ch3 commits 10 bytes, then sends 8 bytes.
  - Response: drop_out[3] pulses once on the 7th byte. Raising out_ready yields only the 10-byte packet. A subsequent 3-byte ch3 packet is delivered intact.
- Backpressure:
  - Stimulus: out_ready toggles 1,0,0,1 during a 4-byte packet.
  - Response: out_data, sop, eop and out_ch stay stable while stalled; no byte is lost or duplicated.
- Reset mid-transfer:
  - Stimulus: assert rst_n=0 asynchronously between clock edges during byte 2 of 5.
  - Response: out_valid=0 immediately. After release, no output occurs until a new packet is committed.
